// File: rtl/inst_mem_if.sv
// Fetch and program-load bus between the IF stage (or a boot loader) and inst_mem_loadable.
// A fetch request has no ready signal. It is accepted on the edge where fetch_req=1,
// fetch_stall=0 and busy=0, and its result appears in inst/inst_valid/inst_fault
// after that edge. While busy=1, requests are dropped and the load port owns the memory.
interface inst_mem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_stall;
  logic [31:0]           inst;
  logic                  inst_valid;
  logic                  inst_fault;
  logic                  load_en;
  logic                  load_we;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [31:0]           load_data;
  logic [3:0]            load_be;
  logic                  busy;
  logic                  load_done;

  modport master (
    output fetch_req, fetch_addr, fetch_stall,
    output load_en, load_we, load_addr, load_data, load_be,
    input  inst, inst_valid, inst_fault, busy, load_done
  );

  modport slave (
    input  fetch_req, fetch_addr, fetch_stall,
    input  load_en, load_we, load_addr, load_data, load_be,
    output inst, inst_valid, inst_fault, busy, load_done
  );
endinterface

// File: rtl/inst_mem_loadable.sv
// Synchronous word-organised instruction memory with a registered fetch port and a
// runtime program-load port. A RUN/LOAD/DRAIN FSM keeps fetches and writes apart.
module inst_mem_loadable #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic       clk,
  input  logic       rst,
  inst_mem_if.slave  bus,
  output logic [1:0] dbg_state
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  load_idx;
  logic              fetch_ok;
  logic              load_in_range;
  logic              load_wr;

  assign dbg_state = state;

  // Upper address bits only feed the range checks, so out-of-range never aliases.
  assign fetch_idx     = bus.fetch_addr[IDX_W+1:2];
  assign fetch_ok      = (bus.fetch_addr[1:0] == 2'b00) &&
                         ((bus.fetch_addr >> (IDX_W + 2)) == '0);
  assign load_idx      = bus.load_addr[IDX_W+1:2];
  assign load_in_range = ((bus.load_addr >> (IDX_W + 2)) == '0);
  assign load_wr       = !rst && (state == ST_LOAD) && bus.load_we && load_in_range;

  // Storage has no reset: a program loaded before a reset survives it.
  always_ff @(posedge clk) begin
    if (load_wr) begin
      if (bus.load_be[0]) mem[load_idx][7:0]   <= bus.load_data[7:0];
      if (bus.load_be[1]) mem[load_idx][15:8]  <= bus.load_data[15:8];
      if (bus.load_be[2]) mem[load_idx][23:16] <= bus.load_data[23:16];
      if (bus.load_be[3]) mem[load_idx][31:24] <= bus.load_data[31:24];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_RUN;
      bus.inst       <= NOP_INST;
      bus.inst_valid <= 1'b0;
      bus.inst_fault <= 1'b0;
      bus.busy       <= 1'b0;
      bus.load_done  <= 1'b0;
    end else begin
      bus.load_done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (bus.load_en) begin
            state    <= ST_LOAD;
            bus.busy <= 1'b1;
          end
        end
        ST_LOAD: begin
          bus.busy <= 1'b1;
          if (!bus.load_en) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state         <= ST_RUN;
          bus.busy      <= 1'b0;
          bus.load_done <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          bus.busy <= 1'b0;
        end
      endcase

      // Stall freezes the output registers in every state, ahead of fetch_req.
      if (!bus.fetch_stall) begin
        if ((state == ST_RUN) && bus.fetch_req) begin
          bus.inst_valid <= 1'b1;
          if (fetch_ok) begin
            bus.inst       <= mem[fetch_idx];
            bus.inst_fault <= 1'b0;
          end else begin
            bus.inst       <= NOP_INST;
            bus.inst_fault <= 1'b1;
          end
        end else begin
          bus.inst       <= NOP_INST;
          bus.inst_valid <= 1'b0;
          bus.inst_fault <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
- Parametrised synchronous instruction memory; next generation of the core's combinational instruction ROM.
- Word-organised storage, byte-addressed little-endian fetch, registered 1-cycle read with stall hold.
- Misalignment / out-of-range fault reporting.
- Runtime program-load port, so a bench or boot controller writes the program instead of hard-wired contents. Sits between the IF-stage PC and the IF/ID register.

Parameters:
- ADDR_WIDTH, 32, fetch/load byte-address width; matches `datawidth.
- DEPTH_WORDS, 256, number of 32-bit instruction words; power of two, 4..65536.
- NOP_INST, 32'h00000013, instruction driven when no valid fetch (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  ADDR_WIDTH  byte address of instruction (PC).
- fetch_stall  in  1  hold current output registers (pipeline stall).
- inst  out  32  fetched instruction, {B[a+3],B[a+2],B[a+1],B[a]}.
- inst_valid  out  1  inst corresponds to an accepted fetch.
- inst_fault  out  1  accepted fetch was misaligned or out of range.
- load_en  in  1  request program-load mode.
- load_we  in  1  write strobe, honoured only in LOAD.
- load_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- load_data  in  32  write word, little-endian byte lanes.
- load_be  in  4  byte enables, bit i writes load_data[8i+7:8i].
- busy  out  1  high in LOAD and DRAIN; fetches rejected.
- load_done  out  1  one-cycle pulse on DRAIN->RUN.

Behaviour:
- Reset (rst=1 at an edge): state=RUN; inst=NOP_INST, inst_valid=0, inst_fault=0, busy=0, load_done=0. Memory contents NOT cleared; contents are undefined until first load. Reset wins over every other input, including mid-load; a partially loaded program is retained.
- FSM states: RUN, LOAD, DRAIN.
  - RUN -> LOAD when load_en=1.
  - LOAD stays while load_en=1; LOAD -> DRAIN when load_en=0.
  - DRAIN -> RUN unconditionally after 1 cycle; load_done=1 during the DRAIN->RUN edge output cycle (registered, high exactly the first RUN cycle).
  - busy registered: 1 in LOAD and DRAIN.
- Fetch in RUN (evaluated at edge N, results visible after edge N):
  - Stall: fetch_stall=1 holds inst/inst_valid/inst_fault unchanged regardless of fetch_req. The stall has priority over fetch_req.
  - Idle: fetch_req=0 with stall=0 gives inst=NOP_INST, inst_valid=0, inst_fault=0.
  - Accepted fetch: fetch_req=1 with stall=0 gives inst_valid=1.
    - Word index w=fetch_addr>>2.
    - Fault if fetch_addr[1:0]!=0 or w>=DEPTH_WORDS (compare full width, no wrap). Then inst=NOP_INST, inst_fault=1.
    - Otherwise inst=mem[w], inst_fault=0.
- Fetch in LOAD/DRAIN: fetch_req ignored; outputs go to NOP_INST, valid=0, fault=0 (stall still holds).
- Load writes: only in LOAD with load_we=1.
  - Word index w=load_addr>>2.
  - w>=DEPTH_WORDS: write silently dropped.
  - Otherwise byte lanes per load_be written at the edge.
  - load_we in RUN/DRAIN is ignored. load_we in the same cycle load_en first rises (still RUN) is ignored.
- Write/read collision impossible by construction (no fetch during LOAD/DRAIN); next-cycle fetch after DRAIN sees all writes.
- Widths: index uses bits [$clog2(DEPTH_WORDS)+1:2]; upper bits only feed range check.

Test Plan:
- Reset then fetch_req=1, addr=0 with memory loaded with addi x9,x0,10 (32'h00A00493) -> next cycle inst=32'h00A00493, valid=1, fault=0.
- Load words 0..5 (six-instruction program: addi/sw/addi/add/lw/add), then fetch 0,4,..,20 back-to-back -> each word returned 1 cycle later; load_done pulses once; busy high exactly from the load_en cycle+1 through DRAIN.
- Fetch addr=6 -> inst=32'h00000013, valid=1, fault=1. Fetch addr=4*DEPTH_WORDS (1024) -> same fault response, no alias to word 0.
- Fetch addr=8, then fetch_stall=1 for 3 cycles with fetch_req=1, addr=12 -> inst holds word 2 for 3 cycles. Release stall -> word 3 next cycle.
- In LOAD, write 32'hFFFFFFFF to word 1 with load_be=4'b0101 over 32'h00000000 -> later fetch addr=4 returns 32'h00FF00FF. Write to addr 4096 is dropped (word 0 unchanged).
- Assert rst mid-LOAD -> next cycle state RUN, busy=0, no load_done pulse. Words written before reset remain fetchable.
